// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the sensor-controller power management slice.
package iot_sensor_pkg;

  typedef enum logic [1:0] {
    PWR_NORMAL = 2'b00,
    PWR_LOW    = 2'b01,
    PWR_SLEEP  = 2'b10,
    PWR_DEEP   = 2'b11
  } pwr_mode_e;

  typedef enum logic [1:0] {
    D_ON   = 2'b00,
    D_WAKE = 2'b01,
    D_OFF  = 2'b10
  } dom_state_e;

  localparam logic [2:0] PWR_STATE_NORMAL = 3'b001;
  localparam logic [2:0] PWR_STATE_LOW    = 3'b010;
  localparam logic [2:0] PWR_STATE_SLEEP  = 3'b100;
  localparam logic [2:0] PWR_STATE_DEEP   = 3'b000;

  function automatic logic [2:0] pwr_state_enc(input pwr_mode_e mode);
    case (mode)
      PWR_NORMAL: return PWR_STATE_NORMAL;
      PWR_LOW:    return PWR_STATE_LOW;
      PWR_SLEEP:  return PWR_STATE_SLEEP;
      default:    return PWR_STATE_DEEP;
    endcase
  endfunction

endpackage

// File: rtl/pwr_domain_mgr_if.sv
// Control/status bundle between the power manager and its system-side controller.
interface pwr_domain_mgr_if #(
  parameter int unsigned NUM_DOMAINS = 6,
  parameter int unsigned CNT_W       = 16
);
  logic                   global_enable;
  logic [NUM_DOMAINS-1:0] activity;
  logic [CNT_W-1:0]       timeout_cfg;
  logic [1:0]             power_mode;
  logic [NUM_DOMAINS-1:0] low_mask;
  logic [NUM_DOMAINS-1:0] sleep_keep_mask;
  logic                   motion_wakeup;
  logic                   timer_wakeup;
  logic [NUM_DOMAINS-1:0] clk_en;
  logic [NUM_DOMAINS-1:0] domain_ready;
  logic [2:0]             power_state;
  logic                   system_wakeup;
  logic [CNT_W-1:0]       idle_counter;
  logic                   power_save_active;

  modport master (
    output global_enable, activity, timeout_cfg, power_mode, low_mask,
           sleep_keep_mask, motion_wakeup, timer_wakeup,
    input  clk_en, domain_ready, power_state, system_wakeup, idle_counter,
           power_save_active
  );

  modport slave (
    input  global_enable, activity, timeout_cfg, power_mode, low_mask,
           sleep_keep_mask, motion_wakeup, timer_wakeup,
    output clk_en, domain_ready, power_state, system_wakeup, idle_counter,
           power_save_active
  );
endinterface

// File: rtl/pwr_domain_fsm.sv
// Single-domain gating FSM: idle timeout in D_ON, settle delay in D_WAKE.
module pwr_domain_fsm
  import iot_sensor_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WAKE_DELAY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             force_off,
  input  logic             activity,
  input  logic [CNT_W-1:0] eff_to,
  output logic             clk_en,
  output logic             ready,
  output logic             is_off
);

  localparam int unsigned WAKE_W = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_DELAY - 1);

  dom_state_e        state;
  logic [CNT_W-1:0]  idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              expire;

  // Gate on the cycle the count reaches eff_to-1 so clk_en drops after exactly eff_to idle cycles.
  assign expire = (eff_to != '0) && (idle_cnt >= (eff_to - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= D_ON;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else if (force_off) begin
      state    <= D_OFF;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        D_ON: begin
          if (activity) begin
            idle_cnt <= '0;
          end else if (expire) begin
            state    <= D_OFF;
            idle_cnt <= '0;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        D_OFF: begin
          if (activity) begin
            state    <= D_WAKE;
            wake_cnt <= '0;
          end
        end
        D_WAKE: begin
          if (wake_cnt == WAKE_LAST) begin
            state    <= D_ON;
            idle_cnt <= '0;
            wake_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + WAKE_W'(1);
          end
        end
        default: state <= D_OFF;
      endcase
    end
  end

  assign clk_en = (state != D_OFF);
  assign ready  = (state == D_ON);
  assign is_off = (state == D_OFF);

endmodule

// File: rtl/pwr_domain_mgr.sv
// Power/clock-enable manager: per-domain gating FSMs plus mode forcing, wake pulse and status.
module pwr_domain_mgr
  import iot_sensor_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 6,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WAKE_DELAY  = 4,
  parameter int unsigned LOW_SHIFT   = 2
) (
  input logic              clk,
  input logic              rst_n,
  pwr_domain_mgr_if.slave  bus
);

  pwr_mode_e              mode;
  logic [NUM_DOMAINS-1:0] force_off;
  logic [NUM_DOMAINS-1:0] clk_en_v;
  logic [NUM_DOMAINS-1:0] ready_v;
  logic [NUM_DOMAINS-1:0] is_off;
  logic [CNT_W-1:0]       eff_to [NUM_DOMAINS];
  logic [CNT_W-1:0]       low_to;
  logic                   all_off;
  logic                   wake_src;
  logic                   wake_prev;
  logic                   wakeup_q;
  logic [2:0]             state_q;
  logic [CNT_W-1:0]       idle_q;

  assign mode   = pwr_mode_e'(bus.power_mode);
  assign low_to = bus.timeout_cfg >> LOW_SHIFT;

  always_comb begin
    force_off = '0;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      force_off[i] = !bus.global_enable || (mode == PWR_DEEP) ||
                     ((mode == PWR_SLEEP) && !bus.sleep_keep_mask[i]);
      eff_to[i]    = ((mode == PWR_LOW) && bus.low_mask[i]) ? low_to : bus.timeout_cfg;
    end
  end

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    pwr_domain_fsm #(
      .CNT_W      (CNT_W),
      .WAKE_DELAY (WAKE_DELAY)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .force_off (force_off[g]),
      .activity  (bus.activity[g]),
      .eff_to    (eff_to[g]),
      .clk_en    (clk_en_v[g]),
      .ready     (ready_v[g]),
      .is_off    (is_off[g])
    );
  end

  assign all_off  = &is_off;
  assign wake_src = (mode == PWR_SLEEP) ? (bus.motion_wakeup | bus.timer_wakeup) :
                    (mode == PWR_DEEP)  ? bus.motion_wakeup : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_prev <= 1'b0;
      wakeup_q  <= 1'b0;
      state_q   <= PWR_STATE_NORMAL;
      idle_q    <= '0;
    end else begin
      wake_prev <= wake_src;
      wakeup_q  <= wake_src & ~wake_prev;
      state_q   <= pwr_state_enc(mode);
      if (bus.global_enable && all_off) begin
        if (idle_q != '1) idle_q <= idle_q + CNT_W'(1);
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign bus.clk_en            = clk_en_v;
  assign bus.domain_ready      = ready_v;
  assign bus.power_state       = state_q;
  assign bus.system_wakeup     = wakeup_q;
  assign bus.idle_counter      = idle_q;
  assign bus.power_save_active = (mode != PWR_NORMAL) || all_off;

endmodule

// File: tb/tb_pwr_domain_mgr.sv
// Directed self-checking bench for pwr_domain_mgr (6 domains, WAKE_DELAY=4, LOW_SHIFT=2).
module tb_pwr_domain_mgr;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  int   pulses;

  pwr_domain_mgr_if #(.NUM_DOMAINS(6), .CNT_W(16)) bus ();

  pwr_domain_mgr #(
    .NUM_DOMAINS (6),
    .CNT_W       (16),
    .WAKE_DELAY  (4),
    .LOW_SHIFT   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.system_wakeup === 1'b1) p++;
    end
  endtask

  task automatic pulse_activity(input logic [5:0] mask);
    bus.activity = mask;
    tick(1);
    bus.activity = '0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.global_enable   = 1'b1;
    bus.activity        = '0;
    bus.timeout_cfg     = 16'd10;
    bus.power_mode      = 2'b00;
    bus.low_mask        = '0;
    bus.sleep_keep_mask = '0;
    bus.motion_wakeup   = 1'b0;
    bus.timer_wakeup    = 1'b0;

    // Reset state
    tick(2);
    check("rst_clk_en", 32'(bus.clk_en), 32'h3f);
    check("rst_ready", 32'(bus.domain_ready), 32'h3f);
    check("rst_pstate", 32'(bus.power_state), 32'h1);
    check("rst_wakeup", 32'(bus.system_wakeup), 32'h0);
    check("rst_idle", 32'(bus.idle_counter), 32'h0);
    rst_n = 1'b1;

    // Timeout 10: still on after 9 edges, off after the 10th
    tick(9);
    check("to10_on", 32'(bus.clk_en), 32'h3f);
    tick(1);
    check("to10_off", 32'(bus.clk_en), 32'h0);
    check("to10_idle0", 32'(bus.idle_counter), 32'h0);
    tick(1);
    check("idle_1", 32'(bus.idle_counter), 32'h1);
    check("psave_alloff", 32'(bus.power_save_active), 32'h1);
    tick(4);
    check("idle_5", 32'(bus.idle_counter), 32'h5);

    // Domain 2 wake latency
    pulse_activity(6'b000100);
    check("wake2_clk_en", 32'(bus.clk_en), 32'h04);
    check("wake2_ready0", 32'(bus.domain_ready), 32'h0);
    check("wake2_idle6", 32'(bus.idle_counter), 32'h6);
    tick(3);
    check("wake2_ready_early", 32'(bus.domain_ready), 32'h0);
    tick(1);
    check("wake2_ready", 32'(bus.domain_ready), 32'h04);
    check("wake2_idle_clr", 32'(bus.idle_counter), 32'h0);
    check("psave_normal", 32'(bus.power_save_active), 32'h0);
    tick(10);
    check("dom2_regate", 32'(bus.clk_en), 32'h0);

    // Activity on the expiry cycle keeps domain 0 on and restarts the count
    pulse_activity(6'b000001);
    tick(4);
    check("dom0_ready", 32'(bus.domain_ready), 32'h01);
    tick(9);
    check("dom0_pre_expiry", 32'(bus.clk_en), 32'h01);
    pulse_activity(6'b000001);
    check("dom0_kept", 32'(bus.clk_en), 32'h01);
    tick(9);
    check("dom0_restart_on", 32'(bus.clk_en), 32'h01);
    tick(1);
    check("dom0_restart_off", 32'(bus.clk_en), 32'h0);

    // LOW mode: domain 0 uses 40>>2 = 10, others 40
    bus.power_mode  = 2'b01;
    bus.timeout_cfg = 16'd40;
    bus.low_mask    = 6'b000001;
    pulse_activity(6'h3f);
    tick(4);
    check("low_ready", 32'(bus.domain_ready), 32'h3f);
    check("low_pstate", 32'(bus.power_state), 32'h2);
    check("low_psave", 32'(bus.power_save_active), 32'h1);
    tick(9);
    check("low_d0_on", 32'(bus.clk_en), 32'h3f);
    tick(1);
    check("low_d0_off", 32'(bus.clk_en), 32'h3e);
    tick(29);
    check("low_rest_on", 32'(bus.clk_en), 32'h3e);
    tick(1);
    check("low_rest_off", 32'(bus.clk_en), 32'h0);

    // NORMAL, timeout 0 never gates
    bus.power_mode  = 2'b00;
    bus.timeout_cfg = 16'd0;
    bus.low_mask    = '0;
    pulse_activity(6'h3f);
    tick(4);
    check("to0_ready", 32'(bus.domain_ready), 32'h3f);
    tick(20);
    check("to0_never", 32'(bus.clk_en), 32'h3f);

    // SLEEP keeps only domain 2; held motion gives one pulse
    bus.power_mode      = 2'b10;
    bus.sleep_keep_mask = 6'b000100;
    tick(1);
    check("sleep_clk_en", 32'(bus.clk_en), 32'h04);
    check("sleep_ready", 32'(bus.domain_ready), 32'h04);
    check("sleep_pstate", 32'(bus.power_state), 32'h4);
    bus.motion_wakeup = 1'b1;
    count_pulses(5, pulses);
    bus.motion_wakeup = 1'b0;
    check("sleep_hold_pulses", 32'(pulses), 32'd1);
    count_pulses(3, pulses);
    check("sleep_after_pulses", 32'(pulses), 32'd0);

    // DEEP ignores timer wakeup and forces everything off
    bus.power_mode   = 2'b11;
    bus.timer_wakeup = 1'b1;
    count_pulses(6, pulses);
    check("deep_timer_pulses", 32'(pulses), 32'd0);
    check("deep_clk_en", 32'(bus.clk_en), 32'h0);
    check("deep_pstate", 32'(bus.power_state), 32'h0);
    bus.timer_wakeup = 1'b0;

    // global_enable dropped while domain 1 is waking
    bus.power_mode = 2'b00;
    pulse_activity(6'b000010);
    check("ge_wake_clk_en", 32'(bus.clk_en), 32'h02);
    tick(2);
    bus.global_enable = 1'b0;
    tick(1);
    check("ge_off_clk_en", 32'(bus.clk_en), 32'h0);
    check("ge_off_ready", 32'(bus.domain_ready), 32'h0);
    check("ge_off_idle", 32'(bus.idle_counter), 32'h0);
    tick(3);
    check("ge_off_idle_hold", 32'(bus.idle_counter), 32'h0);
    bus.global_enable = 1'b1;
    pulse_activity(6'b000010);
    tick(3);
    check("ge_rewake_early", 32'(bus.domain_ready), 32'h0);
    tick(1);
    check("ge_rewake_ready", 32'(bus.domain_ready), 32'h02);

    // Asynchronous reset in the middle of a count
    bus.timeout_cfg     = 16'd10;
    bus.power_mode      = 2'b10;
    bus.sleep_keep_mask = '0;
    tick(3);
    check("pre_rst_clk_en", 32'(bus.clk_en), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_en", 32'(bus.clk_en), 32'h3f);
    check("async_ready", 32'(bus.domain_ready), 32'h3f);
    check("async_pstate", 32'(bus.power_state), 32'h1);
    check("async_idle", 32'(bus.idle_counter), 32'h0);
    bus.power_mode = 2'b00;
    tick(1);
    rst_n = 1'b1;
    tick(9);
    check("post_rst_on", 32'(bus.clk_en), 32'h3f);
    tick(1);
    check("post_rst_off", 32'(bus.clk_en), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
